// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bus of the sequential binary-to-BCD converter.
interface bin2bcd_if;
  logic       start;
  logic [5:0] i;
  logic       busy;
  logic       done;
  logic [2:0] tens;
  logic [3:0] units;

  modport master (output start, i, input busy, done, tens, units);
  modport slave  (input start, i, output busy, done, tens, units);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter (double dabble, one bit per clock).
module bin2bcd_seq (
  input  logic      clk,
  input  logic      rst_b,
  bin2bcd_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  bcd_t, bcd_u;
  logic [5:0]  bin;
  logic [2:0]  cnt;
  logic [2:0]  tens;
  logic [3:0]  units;
  logic [3:0]  adj_t, adj_u;
  logic [13:0] shifted;
  logic        last;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Adjust both digits before the shift; bit 3 of the adjusted tens digit falls off the top.
  always_comb begin
    adj_t   = add3(bcd_t);
    adj_u   = add3(bcd_u);
    shifted = 14'({adj_t, adj_u, bin, 1'b0});
    last    = (cnt == 3'd5);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bcd_t <= '0;
      bcd_u <= '0;
      bin   <= '0;
      cnt   <= '0;
      tens  <= '0;
      units <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bcd_t <= '0;
          bcd_u <= '0;
          bin   <= bus.i;
          cnt   <= '0;
        end
        SHIFT: begin
          {bcd_t, bcd_u, bin} <= shifted;
          cnt <= cnt + 3'd1;
          // Results are captured from the post-shift value so they appear with done.
          if (last) begin
            tens  <= shifted[12:10];
            units <= shifted[9:6];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
  assign bus.tens  = tens;
  assign bus.units = units;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected digits are queued at start and popped on done.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_b;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  logic [6:0] sb[$];

  bin2bcd_if ifc();

  bin2bcd_seq dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] model(input int v);
    logic [2:0] t;
    logic [3:0] u;
    t = 3'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_b === 1'b1) begin
      tests++;
      if (ifc.busy && ifc.done) begin
        fails++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", ifc.busy, ifc.done);
      end
      if (ifc.done) begin
        logic [6:0] exp;
        done_cnt++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got %0d/%0d with no conversion pending", ifc.tens, ifc.units);
        end else begin
          exp = sb.pop_front();
          if ({ifc.tens, ifc.units} !== exp) begin
            fails++;
            $display("FAIL result: got %0d/%0d required %0d/%0d", ifc.tens, ifc.units, exp[6:4], exp[3:0]);
          end
        end
        tests++;
        if (dut.bcd_t[3] !== 1'b0) begin
          fails++;
          $display("FAIL bcd_t_msb: got %0b required 0", dut.bcd_t[3]);
        end
      end
    end
  end

  task automatic start_conv(input int v);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.i     = 6'(v);
    sb.push_back(model(v));
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.i     = 6'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (ifc.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (ifc.done !== 1'b1) begin
      fails++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles required 1", name, ifc.done, n);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    ifc.start = 1'b0;
    ifc.i = '0;
    #3;
    tests++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%0b done=%0b required 0/0", ifc.busy, ifc.done);
    end
    tests++;
    if (ifc.tens !== 3'd0 || ifc.units !== 4'd0) begin
      fails++;
      $display("FAIL reset_digits: got %0d/%0d required 0/0", ifc.tens, ifc.units);
    end
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  task automatic test_max();
    int bc = 0;
    start_conv(63);
    while (ifc.busy === 1'b1 && bc < 20) begin
      bc++;
      @(posedge clk); #1;
    end
    tests++;
    if (bc != 6) begin
      fails++;
      $display("FAIL max_busy_len: got %0d cycles required 6", bc);
    end
    tests++;
    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL max_done_pulse: done=%0b busy=%0b required 1/0", ifc.done, ifc.busy);
    end
    tests++;
    if (ifc.tens !== 3'd6 || ifc.units !== 4'd3) begin
      fails++;
      $display("FAIL max_digits: got %0d/%0d required 6/3", ifc.tens, ifc.units);
    end
    @(posedge clk); #1;
    tests++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      fails++;
      $display("FAIL max_after_e7: done=%0b busy=%0b required 0/0", ifc.done, ifc.busy);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 64; v++) begin
      start_conv(v);
      wait_done("sweep");
      if (v >= 60) begin
        tests++;
        if (ifc.tens !== 3'd6) begin
          fails++;
          $display("FAIL sweep_tens6: i=%0d got %0d required 6", v, ifc.tens);
        end
      end
      if (v == 59) begin
        tests++;
        if (ifc.tens !== 3'd5 || ifc.units !== 4'd9) begin
          fails++;
          $display("FAIL sweep_59: got %0d/%0d required 5/9", ifc.tens, ifc.units);
        end
      end
      if (v == 0) begin
        tests++;
        if (ifc.tens !== 3'd0 || ifc.units !== 4'd0) begin
          fails++;
          $display("FAIL sweep_0: got %0d/%0d required 0/0", ifc.tens, ifc.units);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_change_i();
    int d0 = done_cnt;
    start_conv(47);
    ifc.i = 6'd10;
    ifc.start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    ifc.start = 1'b0;
    wait_done("change_i");
    tests++;
    if (ifc.tens !== 3'd4 || ifc.units !== 4'd7) begin
      fails++;
      $display("FAIL change_i_digits: got %0d/%0d required 4/7", ifc.tens, ifc.units);
    end
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL change_i_pulses: got %0d done pulses required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int k = 0;
    int n = 0;
    repeat (3) sb.push_back(model(25));
    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.i = 6'd25;
    while (k < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ifc.done === 1'b1) begin
        t[k] = cyc;
        k++;
      end
    end
    ifc.start = 1'b0;
    tests++;
    if (k != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses required 3", k);
    end else begin
      tests++;
      if (t[1] - t[0] != 8 || t[2] - t[1] != 8) begin
        fails++;
        $display("FAIL b2b_period: got %0d,%0d cycles required 8,8", t[1] - t[0], t[2] - t[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int d0;
    start_conv(38);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    d0 = done_cnt;
    rst_b = 1'b0;
    #1;
    tests++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      fails++;
      $display("FAIL abort_flags: busy=%0b done=%0b required 0/0", ifc.busy, ifc.done);
    end
    tests++;
    if (ifc.tens !== 3'd0 || ifc.units !== 4'd0) begin
      fails++;
      $display("FAIL abort_digits: got %0d/%0d required 0/0", ifc.tens, ifc.units);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    tests++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - d0);
    end
    start_conv(38);
    wait_done("abort_retry");
    tests++;
    if (ifc.tens !== 3'd3 || ifc.units !== 4'd8) begin
      fails++;
      $display("FAIL abort_retry_digits: got %0d/%0d required 3/8", ifc.tens, ifc.units);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hold();
    int n = 0;
    start_conv(63);
    wait_done("hold_first");
    @(posedge clk); #1;
    start_conv(7);
    while (ifc.done !== 1'b1 && n < 20) begin
      tests++;
      if (ifc.tens !== 3'd6 || ifc.units !== 4'd3) begin
        fails++;
        $display("FAIL hold_old: got %0d/%0d required 6/3", ifc.tens, ifc.units);
      end
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (ifc.done !== 1'b1 || ifc.tens !== 3'd0 || ifc.units !== 4'd7) begin
      fails++;
      $display("FAIL hold_new: done=%0b got %0d/%0d required 1 and 0/7", ifc.done, ifc.tens, ifc.units);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_max();
    test_sweep();
    test_change_i();
    test_back_to_back();
    test_reset_abort();
    test_hold();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d results pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
